// File: rtl/ahb_slave_mux_decoder.sv
// AHB-Lite slave-side interconnect: combinational address decode, registered data-phase
// response mux, and a built-in default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_slave_mux_decoder #(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REGION_LSB = 10,
    parameter int ERRCNT_W   = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] S_HRDATA,
    input  logic [NUM_SLAVES-1:0]        S_HREADYOUT,
    input  logic [NUM_SLAVES-1:0]        S_HRESP,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    input  logic                         err_clr,
    output logic [ERRCNT_W-1:0]          err_cnt
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // One bit wider than HADDR so the end of the mapped space never overflows.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_SLAVES) << REGION_LSB;

    typedef enum logic [1:0] {DSEL_NONE, DSEL_DEF, DSEL_SLV} dsel_kind_e;

    typedef struct packed {
        dsel_kind_e       kind;
        logic [IDX_W-1:0] idx;
    } dsel_t;

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             err_start;
    logic             unused_htrans0;

    dsel_t               dsel_q, dsel_d;
    ds_state_e           state_q, state_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    assign hit            = ({1'b0, HADDR} < LIMIT);
    assign idx            = HADDR[REGION_LSB +: IDX_W];
    assign err_start      = HREADY && !hit && HTRANS[1];
    assign unused_htrans0 = HTRANS[0];
    assign err_cnt        = err_cnt_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        HSEL = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            HSEL[k] = hit && (idx == IDX_W'(k));
        end
    end

    // The data-phase select only advances when the current data phase completes.
    always_comb begin
        dsel_d = dsel_q;
        if (HREADY) begin
            if (hit) begin
                dsel_d.kind = DSEL_SLV;
                dsel_d.idx  = idx;
            end else begin
                dsel_d.kind = DSEL_DEF;
                dsel_d.idx  = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DS_IDLE: if (err_start) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = err_start ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // A clear coinciding with a new ERROR keeps that ERROR in the count.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = ERRCNT_W'(state_d == DS_ERR1);
        end else if (state_d == DS_ERR1 && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        unique case (dsel_q.kind)
            DSEL_SLV: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (dsel_q.idx == IDX_W'(k)) begin
                        HRDATA = S_HRDATA[k*DATA_W +: DATA_W];
                        HREADY = S_HREADYOUT[k];
                        HRESP  = S_HRESP[k];
                    end
                end
            end
            DSEL_DEF: begin
                HREADY = (state_q != DS_ERR1);
                HRESP  = (state_q != DS_IDLE);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q    <= '{kind: DSEL_NONE, idx: '0};
            state_q   <= DS_IDLE;
            err_cnt_q <= '0;
        end else begin
            dsel_q    <= dsel_d;
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux_decoder.sv
// Bench for ahb_slave_mux_decoder: behavioural slaves with configurable wait states, a scoreboard
// of expected data-phase responses, and a monitor that checks each completed data phase.
module tb_ahb_slave_mux_decoder;
    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFC;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSEL;
    logic [95:0] s_hrdata;
    logic [2:0]  s_hreadyout;
    logic [2:0]  s_hresp;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        err_clr;
    logic [7:0]  err_cnt;

    ahb_slave_mux_decoder #(
        .NUM_SLAVES(3), .ADDR_W(32), .DATA_W(32), .REGION_LSB(10), .ERRCNT_W(8)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
        .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   tb_track = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural slaves: wait_cfg[k] wait states, then data_cfg[k]; junk data when not in a data phase.
    int          wait_cfg[3] = '{2, 1, 0};
    logic [31:0] data_cfg[3] = '{32'h1111_0000, 32'hA5A5_0001, 32'h2222_0002};
    bit          busy[3]     = '{0, 0, 0};
    int          cnt[3]      = '{0, 0, 0};
    logic [2:0]  acc_s;
    logic        hready_s;

    initial begin
        s_hreadyout = '1;
        s_hresp     = '0;
        for (int k = 0; k < 3; k++) s_hrdata[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
    end

    always begin
        @(negedge HCLK);
        acc_s    = HSEL & {3{HREADY & HTRANS[1]}};
        hready_s = HREADY;
        @(posedge HCLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!HRESETn) begin
                busy[k] = 1'b0;
            end else begin
                if (busy[k] && hready_s) busy[k] = 1'b0;
                if (acc_s[k]) begin
                    busy[k] = 1'b1;
                    cnt[k]  = wait_cfg[k];
                end
            end
            if (busy[k] && cnt[k] > 0) begin
                s_hreadyout[k]       = 1'b0;
                s_hrdata[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
                cnt[k]--;
            end else if (busy[k]) begin
                s_hreadyout[k]       = 1'b1;
                s_hrdata[k*32 +: 32] = data_cfg[k];
            end else begin
                s_hreadyout[k]       = 1'b1;
                s_hrdata[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
            end
        end
    end

    // Monitor: follows the tracked data phase, checks HRESP during waits and the final response.
    bit dp_pending = 1'b0;
    int wait_cnt   = 0;

    always begin
        @(negedge HCLK);
        if (!HRESETn) begin
            dp_pending = 1'b0;
            wait_cnt   = 0;
        end else begin
            if (dp_pending) begin
                if (!HREADY) begin
                    wait_cnt++;
                    if (sb.size() > 0) check("wait_hresp", 64'(HRESP), 64'(sb[0].resp));
                    if (wait_cnt > 40) begin
                        n_total++;
                        $display("FAIL data_phase_timeout: got %0d wait cycles, required at most 40", wait_cnt);
                        if (sb.size() > 0) void'(sb.pop_front());
                        dp_pending = 1'b0;
                        wait_cnt   = 0;
                    end
                end else begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_underflow: got a completed data phase, required a pending expectation");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("hrdata", 64'(HRDATA), 64'(e.rdata));
                        check("hresp", 64'(HRESP), 64'(e.resp));
                        check("waits", 64'(wait_cnt), 64'(e.waits));
                    end
                    dp_pending = 1'b0;
                    wait_cnt   = 0;
                end
            end
            if (HREADY) dp_pending = tb_track;
        end
    end

    task automatic go_idle();
        HADDR    = IDLE_ADDR;
        HTRANS   = 2'b00;
        tb_track = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Present one address phase (called at posedge+1) and return once it has been accepted.
    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic [2:0] exp_hsel,
                              input bit track, input logic [31:0] exp_data, input logic exp_resp,
                              input int exp_waits, input bit clr);
        int n;
        HADDR    = a;
        HTRANS   = t;
        tb_track = track;
        err_clr  = clr;
        if (track) sb.push_back('{rdata: exp_data, resp: exp_resp, waits: exp_waits});
        @(negedge HCLK);
        check("hsel", 64'(HSEL), 64'(exp_hsel));
        n = 0;
        while (!HREADY && n < 64) begin
            @(negedge HCLK);
            n++;
        end
        if (!HREADY) begin
            n_total++;
            $display("FAIL accept_timeout: got HREADY=0 for %0d cycles, required 1", n);
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        go_idle();
        #12;
        check("rst_hready", 64'(HREADY), 64'h1);
        check("rst_hresp", 64'(HRESP), 64'h0);
        check("rst_hrdata", 64'(HRDATA), 64'h0);
        check("rst_err_cnt", 64'(err_cnt), 64'h0);
        check("rst_hsel", 64'(HSEL), 64'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle_cycles(2);

        // Slave 1 with one wait, then back-to-back slave 0 (two waits) and slave 2.
        addr_phase(32'h0000_0404, 2'b10, 3'b010, 1'b1, 32'hA5A5_0001, 1'b0, 1, 1'b0);
        addr_phase(32'h0000_0000, 2'b10, 3'b001, 1'b1, 32'h1111_0000, 1'b0, 2, 1'b0);
        addr_phase(32'h0000_0800, 2'b10, 3'b100, 1'b1, 32'h2222_0002, 1'b0, 0, 1'b0);
        go_idle();
        idle_cycles(3);

        // Boundary address is unmapped: two-cycle ERROR.
        addr_phase(32'h0000_0C00, 2'b10, 3'b000, 1'b1, 32'h0, 1'b1, 1, 1'b0);
        go_idle();
        idle_cycles(3);
        check("err_cnt_boundary", 64'(err_cnt), 64'h1);

        // IDLE and BUSY to unmapped space: zero-wait OKAY, counter untouched.
        addr_phase(32'hFFFF_0000, 2'b00, 3'b000, 1'b1, 32'h0, 1'b0, 0, 1'b0);
        addr_phase(32'hFFFF_0000, 2'b01, 3'b000, 1'b1, 32'h0, 1'b0, 0, 1'b0);
        go_idle();
        idle_cycles(2);
        check("err_cnt_idle_busy", 64'(err_cnt), 64'h1);

        // Plain clear, then a clear landing on an ERROR entry.
        err_clr = 1'b1;
        idle_cycles(1);
        err_clr = 1'b0;
        @(negedge HCLK);
        check("err_cnt_clear", 64'(err_cnt), 64'h0);
        @(posedge HCLK);
        #1;
        addr_phase(32'h0000_1000, 2'b10, 3'b000, 1'b1, 32'h0, 1'b1, 1, 1'b1);
        go_idle();
        idle_cycles(3);
        check("err_cnt_clr_on_entry", 64'(err_cnt), 64'h1);

        // 256 back-to-back misses saturate the counter, then a mapped access follows an ERR2.
        for (int i = 0; i < 256; i++) begin
            addr_phase(32'h0000_0C00 + 32'(i * 4), (i == 0) ? 2'b10 : 2'b11, 3'b000,
                       1'b1, 32'h0, 1'b1, 1, 1'b0);
        end
        addr_phase(32'h0000_0408, 2'b10, 3'b010, 1'b1, 32'hA5A5_0001, 1'b0, 1, 1'b0);
        go_idle();
        idle_cycles(3);
        check("err_cnt_saturated", 64'(err_cnt), 64'hFF);

        // Asynchronous reset while the default slave sits in ERR1.
        addr_phase(32'h0000_2000, 2'b10, 3'b000, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        go_idle();
        #2;
        check("err1_hready", 64'(HREADY), 64'h0);
        check("err1_hresp", 64'(HRESP), 64'h1);
        HRESETn = 1'b0;
        #1;
        check("rst_mid_hready", 64'(HREADY), 64'h1);
        check("rst_mid_hresp", 64'(HRESP), 64'h0);
        check("rst_mid_err_cnt", 64'(err_cnt), 64'h0);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        idle_cycles(3);
        check("post_rst_hready", 64'(HREADY), 64'h1);
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation time %0t, required completion earlier", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
